// File: rtl/difftest_commit_pkg.sv
// rtl/difftest_commit_pkg.sv - shared record layout and field widths for the difftest commit batcher
package difftest_commit_pkg;

  localparam int PREG_W    = 8;
  localparam int PC_W      = 64;
  localparam int INSTR_W   = 32;
  localparam int ROB_IDX_W = 10;
  localparam int LQ_IDX_W  = 7;
  localparam int SQ_IDX_W  = 7;
  localparam int NFUSED_W  = 8;
  localparam int SPECIAL_W = 8;
  localparam int CORE_ID_W = 8;

  // One committed instruction as seen by the InstrCommit bridge; field order is the wire order.
  typedef struct packed {
    logic                 skip;
    logic                 isRVC;
    logic                 rfwen;
    logic                 fpwen;
    logic                 vecwen;
    logic                 v0wen;
    logic [PREG_W-1:0]    wpdest;
    logic [PREG_W-1:0]    wdest;
    logic [PC_W-1:0]      pc;
    logic [INSTR_W-1:0]   instr;
    logic [ROB_IDX_W-1:0] robIdx;
    logic [LQ_IDX_W-1:0]  lqIdx;
    logic [SQ_IDX_W-1:0]  sqIdx;
    logic                 isLoad;
    logic                 isStore;
    logic [NFUSED_W-1:0]  nFused;
    logic [SPECIAL_W-1:0] special;
  } commit_rec_t;

endpackage

// File: rtl/difftest_commit_compactor.sv
// rtl/difftest_commit_compactor.sv - prefix-sum slot offsets and total count for a channel valid mask
module difftest_commit_compactor
  import difftest_commit_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int KW     = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH-1:0]         valid_i,
  output logic [NUM_CH-1:0][KW-1:0] offset_o,
  output logic [KW-1:0]             count_o
);

  logic [KW-1:0] acc;

  // Each channel's slot is the number of valid channels below it; the running sum ends as k.
  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      offset_o[i] = acc;
      acc         = acc + KW'(valid_i[i]);
    end
    count_o = acc;
  end

endmodule

// File: rtl/difftest_commit_batcher.sv
// rtl/difftest_commit_batcher.sv - multi-channel commit capture buffer draining one record per cycle
module difftest_commit_batcher
  import difftest_commit_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DEPTH  = 32,
  parameter int SEQ_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        io_flush,
  input  logic [NUM_CH-1:0]           io_in_valid,
  input  commit_rec_t [NUM_CH-1:0]    io_in_rec,
  input  logic [CORE_ID_W-1:0]        io_coreid,
  output logic                        io_out_valid,
  input  logic                        io_out_ready,
  output commit_rec_t                 io_out_rec,
  output logic [SEQ_W-1:0]            io_out_seq,
  output logic [CORE_ID_W-1:0]        io_out_coreid,
  output logic                        io_stall,
  output logic                        io_overflow,
  output logic [CNT_W-1:0]            io_drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(NUM_CH + 1);

  typedef logic [SEQ_W-1:0] seq_t;

  // Buffer storage: no reset needed, every read is gated by occupancy.
  commit_rec_t          mem_rec_q  [DEPTH];
  seq_t                 mem_seq_q  [DEPTH];
  logic [CORE_ID_W-1:0] mem_core_q [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  free_now, free_next;
  seq_t           seq_next_q, seq_next_d;
  logic           stall_q, stall_d;
  logic           overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]   drop_sum;

  logic [NUM_CH-1:0]         valid_eff;
  logic [NUM_CH-1:0][KW-1:0] slot_off;
  logic [KW-1:0]             k;
  logic                      fits;
  logic                      accept;
  logic                      drop;
  logic                      pop;

  assign valid_eff = io_in_valid & {NUM_CH{enable}};

  difftest_commit_compactor #(
    .NUM_CH (NUM_CH),
    .KW     (KW)
  ) u_compactor (
    .valid_i  (valid_eff),
    .offset_o (slot_off),
    .count_o  (k)
  );

  // Room is judged against start-of-cycle occupancy, so a same-cycle pop never rescues a batch.
  assign free_now     = CW'(DEPTH) - count_q;
  assign fits         = CW'(k) <= free_now;
  assign accept       = fits && !io_flush;
  assign drop         = !fits && !io_flush;
  assign io_out_valid = (count_q != '0);
  assign pop          = io_out_valid && io_out_ready && !io_flush;

  // Next-state for pointers, occupancy, sequence counter and drop bookkeeping; flush beats push/pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_next_d = seq_next_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(k);
    if (io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        wr_ptr_d   = wr_ptr_q + PW'(k);
        seq_next_d = seq_next_q + SEQ_W'(k);
      end
      if (drop) begin
        overflow_d = 1'b1;
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (accept ? CW'(k) : '0) - (pop ? CW'(1) : '0);
    end
    free_next = CW'(DEPTH) - count_d;
    stall_d   = free_next < CW'(NUM_CH);
  end

  // Control state register; reset clears everything including the sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_next_q <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_next_q <= seq_next_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Scatter the accepted batch into consecutive entries, lowest valid channel first.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (valid_eff[i]) begin
          mem_rec_q[wr_ptr_q + PW'(slot_off[i])]  <= io_in_rec[i];
          mem_seq_q[wr_ptr_q + PW'(slot_off[i])]  <= seq_next_q + SEQ_W'(slot_off[i]);
          mem_core_q[wr_ptr_q + PW'(slot_off[i])] <= io_coreid;
        end
      end
    end
  end

  // Head record presented from storage; zero whenever the buffer is empty.
  always_comb begin
    io_out_rec    = '0;
    io_out_seq    = '0;
    io_out_coreid = '0;
    if (io_out_valid) begin
      io_out_rec    = mem_rec_q[rd_ptr_q];
      io_out_seq    = mem_seq_q[rd_ptr_q];
      io_out_coreid = mem_core_q[rd_ptr_q];
    end
  end

  assign io_stall    = stall_q;
  assign io_overflow = overflow_q;
  assign io_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_difftest_commit_batcher.sv
// tb/tb_difftest_commit_batcher.sv - directed self-checking bench for the commit batcher
module tb_difftest_commit_batcher;
  import difftest_commit_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // Instance A: NUM_CH=8, DEPTH=32, SEQ_W=32
  logic              enable_a, flush_a, ready_a;
  logic [7:0]        valid_a;
  commit_rec_t [7:0] rec_a;
  logic [7:0]        core_a;
  logic              ov_a, stall_a, ovf_a;
  commit_rec_t       orec_a;
  logic [31:0]       oseq_a;
  logic [7:0]        ocore_a;
  logic [15:0]       drop_a;

  // Instance B: NUM_CH=4, DEPTH=16, SEQ_W=4, exercises sequence and pointer wrap
  logic              enable_b, flush_b, ready_b;
  logic [3:0]        valid_b;
  commit_rec_t [3:0] rec_b;
  logic [7:0]        core_b;
  logic              ov_b, stall_b, ovf_b;
  commit_rec_t       orec_b;
  logic [3:0]        oseq_b;
  logic [7:0]        ocore_b;
  logic [3:0]        drop_b;

  difftest_commit_batcher #(.NUM_CH(8), .DEPTH(32), .SEQ_W(32), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .enable(enable_a), .io_flush(flush_a),
    .io_in_valid(valid_a), .io_in_rec(rec_a), .io_coreid(core_a),
    .io_out_valid(ov_a), .io_out_ready(ready_a), .io_out_rec(orec_a),
    .io_out_seq(oseq_a), .io_out_coreid(ocore_a), .io_stall(stall_a),
    .io_overflow(ovf_a), .io_drop_cnt(drop_a)
  );

  difftest_commit_batcher #(.NUM_CH(4), .DEPTH(16), .SEQ_W(4), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b), .io_flush(flush_b),
    .io_in_valid(valid_b), .io_in_rec(rec_b), .io_coreid(core_b),
    .io_out_valid(ov_b), .io_out_ready(ready_b), .io_out_rec(orec_b),
    .io_out_seq(oseq_b), .io_out_coreid(ocore_b), .io_stall(stall_b),
    .io_overflow(ovf_b), .io_drop_cnt(drop_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_a(input logic [63:0] base);
    for (int i = 0; i < 8; i++) begin
      rec_a[i]    = '0;
      rec_a[i].pc = base + 64'(i) * 64'h100;
    end
  endtask

  logic [63:0] exp_pc [4];
  logic [3:0]  exp_sb;

  initial begin
    reset    = 1'b1;
    enable_a = 1'b1; flush_a = 1'b0; ready_a = 1'b0; valid_a = '0; rec_a = '0; core_a = '0;
    enable_b = 1'b1; flush_b = 1'b0; ready_b = 1'b0; valid_b = '0; rec_b = '0; core_b = '0;
    tick();
    tick();
    check("rst_out_valid", ov_a, 0);
    check("rst_stall", stall_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_drop_cnt", drop_a, 0);
    check("rst_out_seq", oseq_a, 0);
    check("rst_out_pc", orec_a.pc, 0);
    reset = 1'b0;

    // Capture disabled: inputs ignored
    enable_a = 1'b0; fill_a(64'h0); valid_a = 8'hFF;
    tick();
    check("enable_off_no_push", ov_a, 0);
    valid_a = '0; enable_a = 1'b1;

    // Sparse mask compaction
    fill_a(64'h0); valid_a = 8'b1010_0101; core_a = 8'h5A;
    check("t1_no_bypass", ov_a, 0);
    tick();
    valid_a = '0;
    check("t1_visible", ov_a, 1);
    check("t1_coreid", ocore_a, 8'h5A);
    exp_pc = '{64'h000, 64'h200, 64'h500, 64'h700};
    ready_a = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("t1_pc", orec_a.pc, exp_pc[j]);
      check("t1_seq", oseq_a, 64'(j));
      tick();
    end
    check("t1_empty", ov_a, 0);
    ready_a = 1'b0;

    // Fill to full without draining, then overflow
    reset = 1'b1; tick(); reset = 1'b0;
    fill_a(64'h1000); valid_a = 8'hFF;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 3) check("t2_stall_low", stall_a, 0);
      if (c == 4) begin
        check("t2_stall_full", stall_a, 1);
        check("t2_no_ovf_yet", ovf_a, 0);
      end
      if (c == 5) begin
        check("t2_overflow", ovf_a, 1);
        check("t2_drop8", drop_a, 8);
      end
    end
    valid_a = '0;
    check("t2_hold_seq", oseq_a, 0);
    check("t2_hold_pc", orec_a.pc, 64'h1000);

    // Full buffer, pop and single push in same cycle: push still drops
    valid_a = 8'h01; ready_a = 1'b1;
    tick();
    valid_a = '0;
    check("t3_drop9", drop_a, 9);
    check("t3_stall", stall_a, 1);
    check("t3_head_seq", oseq_a, 1);
    for (int j = 1; j <= 31; j++) begin
      check("t3_drain_seq", oseq_a, 64'(j));
      tick();
    end
    check("t3_drained", ov_a, 0);
    ready_a = 1'b0;

    // Flush with 10 buffered and 3 incoming
    fill_a(64'h4000); valid_a = 8'hFF;
    tick();
    valid_a = 8'h03;
    tick();
    check("t4_head_seq", oseq_a, 32);
    flush_a = 1'b1; valid_a = 8'h07;
    tick();
    flush_a = 1'b0; valid_a = '0;
    check("t4_flush_empty", ov_a, 0);
    check("t4_drop_kept", drop_a, 9);
    check("t4_ovf_kept", ovf_a, 1);
    check("t4_stall", stall_a, 0);
    fill_a(64'h5000); valid_a = 8'h01;
    tick();
    valid_a = '0;
    check("t4_post_valid", ov_a, 1);
    check("t4_post_seq", oseq_a, 42);
    check("t4_post_pc", orec_a.pc, 64'h5000);
    ready_a = 1'b1;
    tick();
    check("t4_post_drained", ov_a, 0);
    ready_a = 1'b0;

    // Reset mid-stream with 20 queued
    fill_a(64'h6000); valid_a = 8'hFF;
    tick();
    tick();
    valid_a = 8'h0F;
    tick();
    valid_a = '0;
    check("t5_stall20", stall_a, 0);
    reset = 1'b1;
    tick();
    check("t5_out_valid", ov_a, 0);
    check("t5_overflow", ovf_a, 0);
    check("t5_drop_cnt", drop_a, 0);
    check("t5_out_seq", oseq_a, 0);
    check("t5_out_pc", orec_a.pc, 0);
    check("t5_out_core", ocore_a, 0);
    reset = 1'b0;
    fill_a(64'h7000); valid_a = 8'h01;
    tick();
    valid_a = '0;
    check("t5_next_valid", ov_a, 1);
    check("t5_next_seq", oseq_a, 0);

    // Sequence and pointer wrap on instance B
    core_b = 8'hB0;
    for (int i = 0; i < 14; i++) begin
      rec_b[0]    = '0;
      rec_b[0].pc = 64'h1000 + 64'(i);
      valid_b     = 4'h1;
      tick();
    end
    valid_b = '0;
    check("w_stall14", stall_b, 1);
    ready_b = 1'b1;
    for (int i = 0; i < 14; i++) begin
      exp_sb = 4'(i);
      check("w_pre_seq", oseq_b, exp_sb);
      check("w_pre_pc", orec_b.pc, 64'h1000 + 64'(i));
      tick();
    end
    check("w_pre_empty", ov_b, 0);
    ready_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rec_b[i]    = '0;
      rec_b[i].pc = 64'h2000 + 64'(i);
    end
    valid_b = 4'hF;
    tick();
    valid_b = '0;
    check("w_drop_none", drop_b, 0);
    ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_sb = 4'(14 + i);
      check("w_seq", oseq_b, exp_sb);
      check("w_pc", orec_b.pc, 64'h2000 + 64'(i));
      check("w_core", ocore_b, 8'hB0);
      tick();
    end
    check("w_empty", ov_b, 0);
    ready_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
